// File: rtl/stopwatch_lap_dp.sv
// hh:mm:ss.cc stopwatch/timer datapath with up/down counting, preset load and a FWFT lap buffer.
// Define LAP_DELTA_EN to store split times (elapsed since the previous lap) instead of absolute times.
module stopwatch_lap_dp #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4,
  parameter int HOUR_MAX  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_run,
  input  logic                         i_mode_down,
  input  logic                         i_clear,
  input  logic                         i_load,
  input  logic [23:0]                  i_load_time,
  input  logic                         i_lap,
  input  logic                         i_lap_rd,
  output logic [6:0]                   msec,
  output logic [5:0]                   sec,
  output logic [5:0]                   min,
  output logic [4:0]                   hour,
  output logic [23:0]                  o_lap_time,
  output logic                         o_lap_valid,
  output logic [$clog2(LAP_DEPTH):0]   o_lap_count,
  output logic                         o_lap_drop,
  output logic                         o_rollover,
  output logic                         o_expired
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam logic [PSW-1:0] PS_LAST  = PSW'(DIV - 1);
  localparam logic [4:0]     H_LAST   = 5'(HOUR_MAX - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(LAP_DEPTH);

  logic [PSW-1:0] presc;
  logic           run_en, tick;
  logic [23:0]    cur_time, load_sat, lap_entry;
  logic [6:0]     nx_cs;
  logic [5:0]     nx_s, nx_m;
  logic [4:0]     nx_h;
  logic           nx_roll, nx_exp;

  assign run_en   = i_run && !o_expired;
  assign tick     = run_en && (presc == PS_LAST);
  assign cur_time = {hour, min, sec, msec};

  always_comb begin
    load_sat[23:19] = (i_load_time[23:19] > H_LAST) ? H_LAST : i_load_time[23:19];
    load_sat[18:13] = (i_load_time[18:13] > 6'd59) ? 6'd59 : i_load_time[18:13];
    load_sat[12:7]  = (i_load_time[12:7]  > 6'd59) ? 6'd59 : i_load_time[12:7];
    load_sat[6:0]   = (i_load_time[6:0]   > 7'd99) ? 7'd99 : i_load_time[6:0];
  end

  // All four fields resolve their carry/borrow chain combinationally so they change on one edge.
  always_comb begin
    nx_cs   = msec;
    nx_s    = sec;
    nx_m    = min;
    nx_h    = hour;
    nx_roll = 1'b0;
    nx_exp  = 1'b0;
    if (!i_mode_down) begin
      if (msec != 7'd99) nx_cs = msec + 7'd1;
      else begin
        nx_cs = 7'd0;
        if (sec != 6'd59) nx_s = sec + 6'd1;
        else begin
          nx_s = 6'd0;
          if (min != 6'd59) nx_m = min + 6'd1;
          else begin
            nx_m = 6'd0;
            if (hour != H_LAST) nx_h = hour + 5'd1;
            else begin
              nx_h    = 5'd0;
              nx_roll = 1'b1;
            end
          end
        end
      end
    end else if (cur_time == 24'd0) begin
      nx_exp = 1'b1;
    end else begin
      if (msec != 7'd0) nx_cs = msec - 7'd1;
      else begin
        nx_cs = 7'd99;
        if (sec != 6'd0) nx_s = sec - 6'd1;
        else begin
          nx_s = 6'd59;
          if (min != 6'd0) nx_m = min - 6'd1;
          else begin
            nx_m = 6'd59;
            nx_h = hour - 5'd1;
          end
        end
      end
      nx_exp = ({nx_h, nx_m, nx_s, nx_cs} == 24'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      {hour, min, sec, msec} <= 24'd0;
      o_rollover <= 1'b0;
      o_expired  <= 1'b0;
    end else if (i_clear) begin
      presc      <= '0;
      {hour, min, sec, msec} <= 24'd0;
      o_rollover <= 1'b0;
      o_expired  <= 1'b0;
    end else if (i_load) begin
      presc      <= '0;
      {hour, min, sec, msec} <= load_sat;
      o_rollover <= 1'b0;
      o_expired  <= 1'b0;
    end else begin
      o_rollover <= 1'b0;
      if (run_en) presc <= tick ? '0 : presc + PSW'(1);
      if (tick) begin
        {hour, min, sec, msec} <= {nx_h, nx_m, nx_s, nx_cs};
        o_rollover <= nx_roll;
        if (nx_exp) o_expired <= 1'b1;
      end
    end
  end

`ifdef LAP_DELTA_EN
  logic [23:0] mark;

  // Mixed-radix a - b with borrow; a negative result wraps modulo HOUR_MAX:60:60:100.
  function automatic logic [23:0] sub_time(input logic [23:0] a, input logic [23:0] b);
    logic [6:0] cs;
    logic [5:0] s, m;
    logic [4:0] h;
    logic       bc, bs, bm, bh;
    bc = a[6:0] < b[6:0];
    cs = a[6:0] - b[6:0] + (bc ? 7'd100 : 7'd0);
    bs = a[12:7] < (b[12:7] + {5'd0, bc});
    s  = a[12:7] - b[12:7] - {5'd0, bc} + (bs ? 6'd60 : 6'd0);
    bm = a[18:13] < (b[18:13] + {5'd0, bs});
    m  = a[18:13] - b[18:13] - {5'd0, bs} + (bm ? 6'd60 : 6'd0);
    bh = {1'b0, a[23:19]} < ({1'b0, b[23:19]} + {5'd0, bm});
    h  = a[23:19] - b[23:19] - {4'd0, bm} + (bh ? 5'(HOUR_MAX) : 5'd0);
    return {h, m, s, cs};
  endfunction

  assign lap_entry = i_mode_down ? sub_time(mark, cur_time) : sub_time(cur_time, mark);
`else
  assign lap_entry = cur_time;
`endif

  logic [23:0]   lap_mem [LAP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push;

  assign o_lap_valid = (o_lap_count != '0);
  assign full        = (o_lap_count == FULL_CNT);
  assign pop         = i_lap_rd && o_lap_valid;
  assign push        = i_lap && (!full || pop);
  assign o_lap_time  = o_lap_valid ? lap_mem[rd_ptr] : 24'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_lap_count <= '0;
      o_lap_drop  <= 1'b0;
    end else if (i_clear || i_load) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_lap_count <= '0;
      o_lap_drop  <= 1'b0;
    end else begin
      o_lap_drop <= i_lap && !push;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      o_lap_count <= o_lap_count + CW'(1);
      else if (pop && !push) o_lap_count <= o_lap_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !i_clear && !i_load) lap_mem[wr_ptr] <= lap_entry;
  end

`ifdef LAP_DELTA_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              mark <= 24'd0;
    else if (i_clear)                     mark <= 24'd0;
    else if (i_load)                      mark <= load_sat;
    else if (push)                        mark <= cur_time;
  end
`endif

endmodule

// File: tb/tb_stopwatch_lap_dp.sv
// Bench for stopwatch_lap_dp: directed vector table, lap-buffer sequences, and random traffic
// checked every cycle against a model that keeps time as a single centisecond count.
module tb_stopwatch_lap_dp;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEPTH = 4;
  localparam int HMAX = 24;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TOT = HMAX * 360000;

  logic        clk, rst;
  logic        i_run, i_mode_down, i_clear, i_load, i_lap, i_lap_rd;
  logic [23:0] i_load_time;
  logic [6:0]  sw_cs;
  logic [5:0]  sw_s, sw_m;
  logic [4:0]  sw_h;
  logic [23:0] o_lap_time;
  logic        o_lap_valid, o_lap_drop, o_rollover, o_expired;
  logic [2:0]  o_lap_count;

  stopwatch_lap_dp #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(DEPTH), .HOUR_MAX(HMAX)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_mode_down(i_mode_down), .i_clear(i_clear),
    .i_load(i_load), .i_load_time(i_load_time), .i_lap(i_lap), .i_lap_rd(i_lap_rd),
    .msec(sw_cs), .sec(sw_s), .min(sw_m), .hour(sw_h), .o_lap_time(o_lap_time),
    .o_lap_valid(o_lap_valid), .o_lap_count(o_lap_count), .o_lap_drop(o_lap_drop),
    .o_rollover(o_rollover), .o_expired(o_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int          m_t, m_presc, m_mark;
  bit          m_exp, m_roll, m_drop;
  logic [23:0] m_q[$];

  function automatic logic [23:0] pk(int h, int m, int s, int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [23:0] pk_int(int t);
    return pk(t / 360000, (t / 6000) % 60, (t / 100) % 60, t % 100);
  endfunction

  function automatic int sat_int(logic [23:0] v);
    int h, m, s, c;
    h = int'(v[23:19]); m = int'(v[18:13]); s = int'(v[12:7]); c = int'(v[6:0]);
    if (h > HMAX - 1) h = HMAX - 1;
    if (m > 59) m = 59;
    if (s > 59) s = 59;
    if (c > 99) c = 99;
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit run, input bit down, input bit clr, input bit ld,
                            input logic [23:0] lt, input bit lap, input bit rd);
    bit tick, pop;
    int cur;
    logic [23:0] ent;
    m_roll = 0;
    m_drop = 0;
    if (clr || ld) begin
      m_t = clr ? 0 : sat_int(lt);
      m_presc = 0;
      m_q.delete();
      m_exp = 0;
      m_mark = m_t;
    end else begin
      cur = m_t;
      tick = run && !m_exp && (m_presc == DIV - 1);
      if (run && !m_exp) m_presc = (m_presc + 1) % DIV;
      pop = rd && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (lap) begin
        if (m_q.size() < DEPTH) begin
`ifdef LAP_DELTA_EN
          ent = pk_int(down ? (m_mark - cur + TOT) % TOT : (cur - m_mark + TOT) % TOT);
          m_mark = cur;
`else
          ent = pk_int(cur);
`endif
          m_q.push_back(ent);
        end else m_drop = 1;
      end
      if (tick) begin
        if (!down) begin
          m_t++;
          if (m_t == TOT) begin m_t = 0; m_roll = 1; end
        end else if (m_t == 0) m_exp = 1;
        else begin
          m_t--;
          if (m_t == 0) m_exp = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("time", {sw_h, sw_m, sw_s, sw_cs}, pk_int(m_t));
    check("expired", o_expired, m_exp);
    check("rollover", o_rollover, m_roll);
    check("lap_drop", o_lap_drop, m_drop);
    check("lap_count", o_lap_count, m_q.size());
    check("lap_valid", o_lap_valid, m_q.size() > 0);
    check("lap_time", o_lap_time, (m_q.size() > 0) ? m_q[0] : 24'd0);
  endtask

  task automatic cyc(input bit run, input bit down, input bit clr, input bit ld,
                     input logic [23:0] lt, input bit lap, input bit rd);
    i_run = run; i_mode_down = down; i_clear = clr; i_load = ld;
    i_load_time = lt; i_lap = lap; i_lap_rd = rd;
    model_step(run, down, clr, ld, lt, lap, rd);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    string       name;
    bit          run, down, clr, ld;
    logic [23:0] lt;
    int          cycles;
    logic [23:0] exp_time;
    bit          exp_exp, exp_roll;
  } vec_t;

  vec_t vecs[16];
  logic [23:0] lap_exp[4];
  logic [23:0] lt_r;
  bit down_r;

  initial begin
    vecs[0]  = '{"run_1s",      1, 0, 0, 0, 24'd0, 1000, pk(0, 0, 1, 0), 0, 0};
    vecs[1]  = '{"run_part",    1, 0, 0, 0, 24'd0, 5,    pk(0, 0, 1, 0), 0, 0};
    vecs[2]  = '{"hold",        0, 0, 0, 0, 24'd0, 50,   pk(0, 0, 1, 0), 0, 0};
    vecs[3]  = '{"presc_kept",  1, 0, 0, 0, 24'd0, 5,    pk(0, 0, 1, 1), 0, 0};
    vecs[4]  = '{"load_59s",    0, 0, 0, 1, pk(0, 0, 59, 99), 1, pk(0, 0, 59, 99), 0, 0};
    vecs[5]  = '{"carry_min",   1, 0, 0, 0, 24'd0, 10,   pk(0, 1, 0, 0), 0, 0};
    vecs[6]  = '{"load_max",    0, 0, 0, 1, pk(23, 59, 59, 99), 1, pk(23, 59, 59, 99), 0, 0};
    vecs[7]  = '{"rollover",    1, 0, 0, 0, 24'd0, 10,   pk(0, 0, 0, 0), 0, 1};
    vecs[8]  = '{"load_02",     0, 1, 0, 1, pk(0, 0, 0, 2), 1, pk(0, 0, 0, 2), 0, 0};
    vecs[9]  = '{"expire",      1, 1, 0, 0, 24'd0, 30,   pk(0, 0, 0, 0), 1, 0};
    vecs[10] = '{"frozen",      1, 1, 0, 0, 24'd0, 20,   pk(0, 0, 0, 0), 1, 0};
    vecs[11] = '{"clear",       0, 1, 1, 0, 24'd0, 1,    pk(0, 0, 0, 0), 0, 0};
    vecs[12] = '{"load_sat",    0, 1, 0, 1, 24'hFFFFFF, 1, pk(23, 59, 59, 99), 0, 0};
    vecs[13] = '{"down_tick",   1, 1, 0, 0, 24'd0, 10,   pk(23, 59, 59, 98), 0, 0};
    vecs[14] = '{"load_1h",     0, 1, 0, 1, pk(1, 0, 0, 0), 1, pk(1, 0, 0, 0), 0, 0};
    vecs[15] = '{"borrow_hour", 1, 1, 0, 0, 24'd0, 10,   pk(0, 59, 59, 99), 0, 0};

    i_run = 0; i_mode_down = 0; i_clear = 0; i_load = 0; i_load_time = 0; i_lap = 0; i_lap_rd = 0;
    m_t = 0; m_presc = 0; m_mark = 0; m_exp = 0; m_roll = 0; m_drop = 0;
    rst = 1'b1;
    #23;
    compare_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].cycles; k++)
        cyc(vecs[v].run, vecs[v].down, vecs[v].clr, vecs[v].ld, vecs[v].lt, 0, 0);
      check({vecs[v].name, "_time"}, {sw_h, sw_m, sw_s, sw_cs}, vecs[v].exp_time);
      check({vecs[v].name, "_exp"}, o_expired, vecs[v].exp_exp);
      check({vecs[v].name, "_roll"}, o_rollover, vecs[v].exp_roll);
    end

    // Fill past full: laps taken at .01 .. .05, the fifth is dropped.
    cyc(0, 0, 1, 0, 0, 0, 0);
`ifdef LAP_DELTA_EN
    lap_exp = '{pk(0, 0, 0, 1), pk(0, 0, 0, 1), pk(0, 0, 0, 1), pk(0, 0, 0, 1)};
`else
    lap_exp = '{pk(0, 0, 0, 1), pk(0, 0, 0, 2), pk(0, 0, 0, 3), pk(0, 0, 0, 4)};
`endif
    for (int k = 0; k < 5; k++) begin
      repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    check("full_count", o_lap_count, 3'd4);
    check("full_drop", o_lap_drop, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("pop_order", o_lap_time, lap_exp[k]);
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    check("drained_valid", o_lap_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("pop_empty_count", o_lap_count, 3'd0);

    // Refill (.06 .. .09), then push .10 with a simultaneous pop while full.
    for (int k = 0; k < 4; k++) begin
      repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("pushpop_count", o_lap_count, 3'd4);
    check("pushpop_drop", o_lap_drop, 1'b0);
`ifndef LAP_DELTA_EN
    check("pushpop_head", o_lap_time, pk(0, 0, 0, 7));
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    check("pushpop_tail", o_lap_time, pk(0, 0, 0, 10));
`endif
    cyc(0, 0, 1, 0, 0, 1, 0);
    check("clear_flush", o_lap_count, 3'd0);

`ifdef LAP_DELTA_EN
    repeat (300) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (700) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("split_first", o_lap_time, pk(0, 0, 0, 30));
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("split_second", o_lap_time, pk(0, 0, 0, 70));
`endif

    down_r = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) down_r = !down_r;
      case ($urandom_range(0, 3))
        0: lt_r = pk(23, 59, 59, int'($urandom_range(80, 99)));
        1: lt_r = pk(0, 0, 0, int'($urandom_range(0, 30)));
        2: lt_r = 24'($urandom());
        default: lt_r = pk(0, 59, 59, 95);
      endcase
      cyc($urandom_range(0, 9) != 0, down_r, $urandom_range(0, 299) == 0,
          $urandom_range(0, 99) == 0, lt_r, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
